// File: rtl/mem_dump_sequencer.sv
// mem_dump_sequencer: walks START_ADDR..LAST_ADDR on a synchronous byte memory,
// waits the fixed read latency, captures each byte and streams it out over a
// valid/ready byte interface.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - begin a dump (accepted only in IDLE)
//   busy, done        - dump in progress / one-cycle end-of-dump pulse
//   mem_address       - registered read address, held stable for the whole read
//   mem_value         - byte returned by the memory READ_LATENCY edges later
//   tx_valid/ready/data - output byte stream
module mem_dump_sequencer #(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned START_ADDR   = 0,
  parameter int unsigned LAST_ADDR    = 31,
  parameter int unsigned STOP_ON_ZERO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_value,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data
);

  // READ_LATENCY is at most 4, so 3 bits hold 0..READ_LATENCY
  localparam int unsigned CNT_W = 3;
  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);
  localparam logic [CNT_W-1:0]  LAT     = CNT_W'(READ_LATENCY);

  typedef enum logic [1:0] {IDLE, READ, SEND, FINISH} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [ADDR_W-1:0]  address_next;
  logic [DATA_W-1:0]  data_next;
  logic               busy_next, done_next, valid_next;

  // State and all outputs are registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_address <= START_A;
      tx_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tx_valid    <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      mem_address <= address_next;
      tx_data     <= data_next;
      busy        <= busy_next;
      done        <= done_next;
      tx_valid    <= valid_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    address_next = mem_address;
    data_next    = tx_data;

    unique case (state)
      IDLE: begin
        if (start) begin
          address_next = START_A;
          cnt_next     = '0;
          state_next   = READ;
        end
      end
      READ: begin
        cnt_next = cnt + CNT_W'(1);
        // mem_value now reflects the address issued at cnt==0
        if (cnt == LAT) begin
          data_next = mem_value;
          if ((STOP_ON_ZERO != 0) && (mem_value == '0)) state_next = FINISH;
          else                                           state_next = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (mem_address == LAST_A) begin
            state_next = FINISH;
          end else begin
            address_next = mem_address + ADDR_W'(1);
            cnt_next     = '0;
            state_next   = READ;
          end
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    busy_next  = (state_next == READ) || (state_next == SEND);
    done_next  = (state_next == FINISH);
    valid_next = (state_next == SEND);
  end

endmodule
